// File: rtl/pc_gen.sv
// Instruction-fetch PC generator: sequential fetch, flush/branch redirect, and a
// one-entry buffer that holds a branch resolved while fetch is stalled.
module pc_gen #(
  parameter int              AW         = 32,
  parameter logic [AW-1:0]   RESET_VEC  = '0,
  parameter int              INC        = 4,
  parameter int              STALL_W    = 6,
  parameter int              ALIGN_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [AW-1:0]      new_pc,
  input  logic               branch_flag_i,
  input  logic [AW-1:0]      branch_target_address_i,
  output logic [AW-1:0]      pc,
  output logic               ce,
  output logic               pc_misaligned_o,
  output logic               redirect_pending_o
);

  logic [AW-1:0] pc_q, pc_d;
  logic          ce_q;
  logic          pend_vld_q, pend_vld_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;

  // Priority: disabled fetch > flush > stall > live branch > pending > increment.
  always_comb begin
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    if (!ce_q) begin
      pc_d       = RESET_VEC;
      pend_vld_d = 1'b0;
    end else if (flush) begin
      pc_d       = new_pc;
      pend_vld_d = 1'b0;
    end else if (stall[0]) begin
      if (branch_flag_i) begin
        pend_addr_d = branch_target_address_i;
        pend_vld_d  = 1'b1;
      end
    end else if (branch_flag_i) begin
      pc_d       = branch_target_address_i;
      pend_vld_d = 1'b0;
    end else if (pend_vld_q) begin
      pc_d       = pend_addr_q;
      pend_vld_d = 1'b0;
    end else begin
      pc_d = pc_q + AW'(INC);
    end
  end

  // pc has no reset of its own: it is reloaded from RESET_VEC once ce is seen low.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (rst) begin
      ce_q        <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      ce_q        <= 1'b1;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  generate
    if (ALIGN_BITS == 0) begin : g_no_align
      assign pc_misaligned_o = 1'b0;
    end else begin : g_align
      assign pc_misaligned_o = ce_q & (|pc_q[ALIGN_BITS-1:0]);
    end
    if (STALL_W > 1) begin : g_stall_hi
      logic unused_stall;
      assign unused_stall = ^stall[STALL_W-1:1];
    end
  endgenerate

  assign pc                 = pc_q;
  assign ce                 = ce_q;
  assign redirect_pending_o = pend_vld_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised instruction-fetch PC generator for the 5-stage pipeline; drives the instruction-memory address and chip enable.
- Adds several behaviours beyond a plain PC register:
  - configurable address width, reset vector and increment;
  - exception/flush redirect that overrides stall;
  - a one-entry pending-redirect buffer, so a branch resolved during a stall is held and applied when the stall releases;
  - misaligned-PC flagging for the exception unit.

Parameters:
AW, 32, PC/address width in bits
RESET_VEC, 32'h0000_0000 (AW bits), PC value while fetch is disabled
INC, 4, sequential PC increment
STALL_W, 6, width of stall vector from ctrl; only bit 0 (fetch stage) is used
ALIGN_BITS, 2, number of PC LSBs that must be zero for an aligned fetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  STALL_W  per-stage stall from ctrl; stall[0]=1 holds the fetch stage
flush  in  1  exception/eret redirect request from ctrl
new_pc  in  AW  redirect target, valid with flush
branch_flag_i  in  1  branch/jump taken, from ID
branch_target_address_i  in  AW  branch target, valid with branch_flag_i
pc  out  AW  current fetch address
ce  out  1  instruction-memory chip enable
pc_misaligned_o  out  1  current pc violates alignment
redirect_pending_o  out  1  pending-redirect buffer occupied

Behaviour:
- Reset (rst=1 at edge):
  - ce<=0, pending_valid<=0, pending_addr<=0.
  - pc is loaded by the ce==0 rule below: RESET_VEC on the edge after ce is seen low.
- ce register:
  - ce<=0 while rst=1, else ce<=1.
  - ce rises on the first edge with rst=0.
- PC update when ce==0 (registered ce sampled at the edge): pc<=RESET_VEC, pending cleared; all other inputs ignored.
  - Consequence: the first fetch address is RESET_VEC, presented with ce=1 for at least one cycle.
- PC update when ce==1, strict priority:
  1. flush=1: pc<=new_pc and pending_valid<=0, regardless of stall[0] or branch_flag_i.
  2. stall[0]=1: pc holds.
     - If branch_flag_i=1: pending_addr<=branch_target_address_i and pending_valid<=1. A newer branch during the same stall overwrites the buffer.
     - Otherwise the buffer is unchanged.
  3. stall[0]=0, branch_flag_i=1: pc<=branch_target_address_i and pending_valid<=0. The live branch wins over a stale pending entry.
  4. stall[0]=0, pending_valid=1: pc<=pending_addr and pending_valid<=0.
  5. Otherwise: pc<=pc+INC, truncated to AW bits; wraps modulo 2^AW with no flag.
- Latency: one cycle from redirect input to new pc. A pending redirect is applied on the first edge with stall[0]=0.
- pc_misaligned_o:
  - Combinational: ce & (pc[ALIGN_BITS-1:0]!=0).
  - Tied 0 when ALIGN_BITS=0.
  - No other effect inside the block; pc is still driven.
- redirect_pending_o = pending_valid, registered.
- stall[STALL_W-1:1] are unused.
- Reset mid-operation: pending contents discarded; next ce==1 cycle fetches from RESET_VEC.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0, no stall -> ce 0→1 on first edge; pc=0x0 for 2 cycles, then 0x4, 0x8, 0xC.
- Branch unstalled: pc=0x10, branch_flag_i=1, target=0x100 for one cycle -> next pc=0x100, then 0x104.
- Branch during stall: stall[0]=1 for 3 cycles at pc=0x20; branch target 0x200 in cycle 1 and 0x300 in cycle 2 -> pc holds 0x20 and redirect_pending_o=1 from cycle 2; on release pc=0x300 and pending clears, then 0x304.
- Flush over stall and pending: pending=0x400, stall[0]=1, flush=1, new_pc=0x180 -> next pc=0x180, redirect_pending_o=0; after stall releases, pc=0x184.
- Wrap and misalignment: AW=32, pc=0xFFFF_FFFC -> next pc=0x0. Branch to 0x102 -> pc_misaligned_o=1 in that cycle, 0 after the next redirect to 0x200.
- Reset mid-pending: pending_valid=1, assert rst for 1 cycle -> pending cleared; pc returns to RESET_VEC and counts 0x0, 0x4.
